// File: rtl/gated_updown_counter.sv
// gated_updown_counter: WIDTH-bit modulo-MOD up/down counter.
// The count register is clocked through an integrated clock gating cell, so
// it only sees an edge on cycles that request work (count, clear, load or
// scan bypass). An ungated idle monitor reports long gate-closed stretches.

// Integrated clock gating cell: the enable is captured while clk_in is low,
// so clk_out can only pulse for a full high phase and never glitches.
module gated_updown_icg (
  input  logic clk_in,
  input  logic enable,
  output logic clk_out
);
  logic en_latch;

  // Transparent-low enable latch.
  always_latch begin
    if (!clk_in) en_latch <= enable;
  end

  assign clk_out = clk_in & en_latch;
endmodule

module gated_updown_counter #(
  parameter int          WIDTH       = 8,
  parameter longint      MOD         = longint'(1) << WIDTH,
  parameter bit          SATURATE    = 1'b0,
  parameter int          IDLE_THRESH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             test_en,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             gate_open,
  output logic             idle
);
  // All count arithmetic runs one bit wider than the register so that the
  // upper bound and the +1 step never alias when the modulus is below 2**WIDTH.
  localparam logic [WIDTH:0] MAX_W    = (WIDTH+1)'(MOD - 64'd1);
  localparam logic [WIDTH:0] ONE_W    = (WIDTH+1)'(1);
  localparam logic [15:0]    THRESH_W = 16'(IDLE_THRESH);

  logic             gate_req;
  logic             gated_clk;
  logic [WIDTH-1:0] count_q,    count_d;
  logic             wrap_q,     wrap_d;
  logic             gate_open_q;
  logic [15:0]      idle_cnt_q, idle_cnt_d;
  logic             idle_q,     idle_d;
  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   load_ext;
  logic [WIDTH:0]   count_nxt;
  logic             at_bound;

  assign gate_req = en | clr | load | test_en;

  gated_updown_icg u_icg (
    .clk_in  (clk),
    .enable  (gate_req),
    .clk_out (gated_clk)
  );

  // Next count: clr beats load beats en; test_en alone just holds.
  always_comb begin
    count_ext = {1'b0, count_q};
    load_ext  = {1'b0, load_val};
    count_nxt = count_ext;
    at_bound  = 1'b0;
    if (clr) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = (load_ext > MAX_W) ? MAX_W : load_ext;
    end else if (en) begin
      if (up_dn) begin
        at_bound  = (count_ext == MAX_W);
        count_nxt = at_bound ? (SATURATE ? MAX_W : '0) : count_ext + ONE_W;
      end else begin
        at_bound  = (count_ext == '0);
        count_nxt = at_bound ? (SATURATE ? '0 : MAX_W) : count_ext - ONE_W;
      end
    end
    count_d = count_nxt[WIDTH-1:0];
    wrap_d  = at_bound;
  end

  // Idle run length: restarts on any request, otherwise climbs to threshold.
  always_comb begin
    if (gate_req)                    idle_cnt_d = '0;
    else if (idle_cnt_q == THRESH_W) idle_cnt_d = idle_cnt_q;
    else                             idle_cnt_d = idle_cnt_q + 16'd1;
    idle_d = (idle_cnt_d == THRESH_W);
  end

  // Count register: the only flop on the gated clock.
  always_ff @(posedge gated_clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  // Free-running flops: wrap pulse, gate status and idle monitor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q      <= 1'b0;
      gate_open_q <= 1'b0;
      idle_cnt_q  <= '0;
      idle_q      <= 1'b0;
    end else begin
      wrap_q      <= wrap_d;
      gate_open_q <= gate_req;
      idle_cnt_q  <= idle_cnt_d;
      idle_q      <= idle_d;
    end
  end

  assign count     = count_q;
  assign wrap      = wrap_q;
  assign gate_open = gate_open_q;
  assign idle      = idle_q;
endmodule

// File: tb/tb_gated_updown_counter.sv
// Bench for gated_updown_counter: a wrapping and a saturating instance share
// the same stimulus and are checked against an arithmetic reference model.
module tb_gated_updown_counter;
  localparam int     W    = 4;
  localparam longint MODV = 10;
  localparam int     TH   = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0, up_dn = 1'b0, clr = 1'b0, load = 1'b0, test_en = 1'b0;
  logic [W-1:0] load_val = '0;

  logic [W-1:0] count_w, count_s;
  logic         wrap_w, wrap_s, gate_w, gate_s, idle_w, idle_s;

  int checks = 0;
  int errors = 0;

  // Reference model state: index 0 = wrapping, 1 = saturating.
  int m_cnt[2];
  bit m_wrap[2];
  bit m_gate;
  int m_quiet;

  // Clock
  always #5 clk = ~clk;

  gated_updown_counter #(.WIDTH(W), .MOD(MODV), .SATURATE(1'b0), .IDLE_THRESH(TH)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .test_en(test_en), .count(count_w), .wrap(wrap_w),
    .gate_open(gate_w), .idle(idle_w)
  );

  gated_updown_counter #(.WIDTH(W), .MOD(MODV), .SATURATE(1'b1), .IDLE_THRESH(TH)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .test_en(test_en), .count(count_s), .wrap(wrap_s),
    .gate_open(gate_s), .idle(idle_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]  = 0;
      m_wrap[i] = 1'b0;
    end
    m_gate  = 1'b0;
    m_quiet = 0;
  endtask

  // One clock of the specified behaviour, from the inputs about to be sampled.
  task automatic model_step();
    bit req;
    bit sat;
    int lv;
    req = en | clr | load | test_en;
    lv  = int'(load_val);
    for (int i = 0; i < 2; i++) begin
      sat = (i == 1);
      m_wrap[i] = 1'b0;
      if (clr) begin
        m_cnt[i] = 0;
      end else if (load) begin
        m_cnt[i] = (lv >= MODV) ? int'(MODV) - 1 : lv;
      end else if (en) begin
        if (up_dn) begin
          if (m_cnt[i] + 1 == MODV) begin
            m_wrap[i] = 1'b1;
            m_cnt[i]  = sat ? m_cnt[i] : 0;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end else begin
          if (m_cnt[i] == 0) begin
            m_wrap[i] = 1'b1;
            m_cnt[i]  = sat ? 0 : int'(MODV) - 1;
          end else begin
            m_cnt[i] = m_cnt[i] - 1;
          end
        end
      end
    end
    m_gate  = req;
    m_quiet = req ? 0 : m_quiet + 1;
  endtask

  task automatic check_all(input string tag);
    bit exp_idle;
    exp_idle = (m_quiet >= TH);
    chk({tag, ":count_w"}, 32'(count_w), 32'(m_cnt[0]));
    chk({tag, ":count_s"}, 32'(count_s), 32'(m_cnt[1]));
    chk({tag, ":wrap_w"},  32'(wrap_w),  32'(m_wrap[0]));
    chk({tag, ":wrap_s"},  32'(wrap_s),  32'(m_wrap[1]));
    chk({tag, ":gate_w"},  32'(gate_w),  32'(m_gate));
    chk({tag, ":gate_s"},  32'(gate_s),  32'(m_gate));
    chk({tag, ":idle_w"},  32'(idle_w),  32'(exp_idle));
    chk({tag, ":idle_s"},  32'(idle_s),  32'(exp_idle));
  endtask

  // Apply inputs, advance one edge, compare just after it.
  task automatic drive(input string tag, input bit e, input bit u, input bit c,
                       input bit l, input int lv, input bit t);
    en       = e;
    up_dn    = u;
    clr      = c;
    load     = l;
    load_val = W'(lv);
    test_en  = t;
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    int n;
    model_reset();

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Count up across the 9 -> 0 boundary
    for (int i = 0; i < 12; i++) drive("up", 1, 1, 0, 0, 0, 0);

    // Load 2, then count down into the lower bound
    drive("load2", 0, 0, 0, 1, 2, 0);
    for (int i = 0; i < 4; i++) drive("down", 1, 0, 0, 0, 0, 0);

    // Priority: clr over load over en, then clamped load
    drive("load5", 0, 0, 0, 1, 5, 0);
    drive("clr_all", 1, 1, 1, 1, 7, 0);
    drive("clamp", 0, 0, 0, 1, 15, 0);

    // Gate closed long enough for idle, then wake with en
    for (int i = 0; i < 6; i++) drive("quiet", 0, 0, 0, 0, 0, 0);
    drive("wake", 1, 1, 0, 0, 0, 0);

    // Scan bypass holds the count and keeps idle low
    for (int i = 0; i < 3; i++) drive("test_en", 0, 1, 0, 0, 0, 1);

    // Async reset while a wrap pulse is showing
    drive("load9", 0, 0, 0, 1, 9, 0);
    drive("wrap9", 1, 1, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    en = 1'b0;
    up_dn = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive("post_rst", 1, 1, 0, 0, 0, 0);

    // Randomized traffic with occasional quiet bursts
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        n = int'($urandom_range(1, 7));
        for (int j = 0; j < n; j++) drive("rnd_quiet", 0, 1'($urandom_range(0, 1)), 0, 0,
                                          int'($urandom_range(0, 15)), 0);
      end else begin
        drive("rnd", $urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)),
              $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 8,
              int'($urandom_range(0, 15)), $urandom_range(0, 99) < 5);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
